lsu_align: RTL

- Load/store alignment unit sitting directly upstream of the data memory, between the core's MEM stage and the memory's word-wide data port.
- Converts RV32I byte, halfword and word loads and stores into word accesses: sign/zero extension on loads, read-modify-write for sub-word stores.
- Exposes a valid/ready request and one-cycle response pulse to the core.

---
 rtl/lsu_align.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/lsu_align.sv
// ============================================================================
// lsu_align : RV32I load/store alignment unit in front of a word-wide memory.
// Optional misalignment trap enabled by defining LSU_MISALIGN_TRAP_EN.
// Revision  : 1.0
// ============================================================================
`default_nettype none

module lsu_align #(
  parameter int ADDR_W = 32,
  parameter int XLEN   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  output logic              resp_valid,
  output logic [XLEN-1:0]   resp_rdata,
  output logic              resp_misaligned,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_r_enable,
  output logic              mem_w_enable,
  output logic [XLEN-1:0]   mem_wdata,
  input  logic [XLEN-1:0]   mem_rdata
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_WAIT = 3'd2,
    S_WR   = 3'd3,
    S_RESP = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic              we_q;
  logic [2:0]        funct3_q;
  logic [ADDR_W-1:0] addr_q;
  logic [XLEN-1:0]   wdata_q;
  logic [XLEN-1:0]   old_q;
  logic [XLEN-1:0]   rdata_q, rdata_d;
  logic [XLEN-1:0]   merge_w;
  logic [7:0]        byte_w;
  logic [15:0]       half_w;
  logic              req_byte_w, req_half_w, req_word_w;
  logic              q_byte_w, q_half_w;
  logic              trap_w;
  logic              accept_w;

  // Reserved width codes (011, 110, 111) fall into the word class.
  assign req_byte_w = (req_funct3[1:0] == 2'b00);
  assign req_half_w = (req_funct3[1:0] == 2'b01);
  assign req_word_w = ~req_byte_w & ~req_half_w;
  assign q_byte_w   = (funct3_q[1:0] == 2'b00);
  assign q_half_w   = (funct3_q[1:0] == 2'b01);
  assign accept_w   = (state_q == S_IDLE) & req_valid;

`ifdef LSU_MISALIGN_TRAP_EN
  logic misal_q;
  assign trap_w = (req_half_w & req_addr[0]) | (req_word_w & (req_addr[1:0] != 2'b00));
  assign resp_misaligned = (state_q == S_RESP) & misal_q;
`else
  assign trap_w = 1'b0;
  assign resp_misaligned = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          if (trap_w)                   state_d = S_RESP;
          else if (req_we && req_word_w) state_d = S_WR;
          else                          state_d = S_RD;
        end
      end
      S_RD:    state_d = S_WAIT;
      S_WAIT:  state_d = we_q ? S_WR : S_RESP;
      S_WR:    state_d = S_RESP;
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    case (addr_q[1:0])
      2'b00:   byte_w = mem_rdata[7:0];
      2'b01:   byte_w = mem_rdata[15:8];
      2'b10:   byte_w = mem_rdata[23:16];
      default: byte_w = mem_rdata[31:24];
    endcase
    half_w = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
  end

  // Load result is only registered in WAIT; cleared on every store or trap accept.
  always_comb begin
    rdata_d = rdata_q;
    if (accept_w && (req_we || trap_w)) begin
      rdata_d = '0;
    end else if (state_q == S_WAIT && !we_q) begin
      if (q_byte_w)
        rdata_d = funct3_q[2] ? {{(XLEN-8){1'b0}}, byte_w} : {{(XLEN-8){byte_w[7]}}, byte_w};
      else if (q_half_w)
        rdata_d = funct3_q[2] ? {{(XLEN-16){1'b0}}, half_w} : {{(XLEN-16){half_w[15]}}, half_w};
      else
        rdata_d = mem_rdata;
    end
  end

  always_comb begin
    merge_w = old_q;
    if (q_byte_w) begin
      case (addr_q[1:0])
        2'b00:   merge_w[7:0]   = wdata_q[7:0];
        2'b01:   merge_w[15:8]  = wdata_q[7:0];
        2'b10:   merge_w[23:16] = wdata_q[7:0];
        default: merge_w[31:24] = wdata_q[7:0];
      endcase
    end else if (q_half_w) begin
      if (addr_q[1]) merge_w[31:16] = wdata_q[15:0];
      else           merge_w[15:0]  = wdata_q[15:0];
    end else begin
      merge_w = wdata_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      we_q     <= 1'b0;
      funct3_q <= 3'b000;
      addr_q   <= '0;
      wdata_q  <= '0;
      old_q    <= '0;
      rdata_q  <= '0;
    end else begin
      state_q <= state_d;
      rdata_q <= rdata_d;
      if (accept_w) begin
        we_q     <= req_we;
        funct3_q <= req_funct3;
        addr_q   <= req_addr;
        wdata_q  <= req_wdata;
      end
      if (state_q == S_WAIT && we_q) begin
        old_q <= mem_rdata;
      end
    end
  end

`ifdef LSU_MISALIGN_TRAP_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           misal_q <= 1'b0;
    else if (accept_w) misal_q <= trap_w;
  end
`endif

  assign req_ready    = (state_q == S_IDLE);
  assign resp_valid   = (state_q == S_RESP);
  assign resp_rdata   = rdata_q;
  assign mem_r_enable = (state_q == S_RD);
  assign mem_w_enable = (state_q == S_WR);
  assign mem_addr     = (state_q == S_RD || state_q == S_WR) ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
  assign mem_wdata    = (state_q == S_WR) ? merge_w : '0;

endmodule

`default_nettype wire
